sprite_compositor: RTL

//  N-channel sprite compositor between vga_controller and the colour outputs; supersedes per-sprite select_pixel + RGB_GEN.
//  Per channel: hit test against h_cnt/v_cnt, BRAM address generation incl. animation frame offset, colour-key transparency.

---
 rtl/sprite_pkg.sv | 27 ++
 rtl/sprite_channel.sv | 71 +++++++
 rtl/sprite_compositor.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared constants, sprite attribute record and frame clamp for the sprite compositor.
// Pure declarations: no latency and no backpressure of its own.
package sprite_pkg;

   localparam logic [11:0] KEY_COLOR_DEF = 12'hF0F;
   localparam int          SPR_POS_W     = 10;
   localparam int          SPR_FRAME_W   = 4;
   localparam int          SIZE_H_DEF    = 20;
   localparam int          SIZE_V_DEF    = 20;
   localparam int          FRAMES_DEF    = 8;
   localparam int          V_ACTIVE_DEF  = 480;

   typedef struct packed {
      logic                   en;
      logic [SPR_POS_W-1:0]   pos_h;
      logic [SPR_POS_W-1:0]   pos_v;
      logic [SPR_FRAME_W-1:0] frame;
   } spr_attr_t;

   // Out-of-range frame indices show the last stored frame.
   function automatic logic [SPR_FRAME_W-1:0] clamp_frame(input logic [SPR_FRAME_W-1:0] f,
                                                          input int frames);
      if (int'(f) >= frames) return SPR_FRAME_W'(frames - 1);
      return f;
   endfunction

endpackage

// File: rtl/sprite_channel.sv
// One sprite channel: frame-shadowed attributes, hit test and BRAM address register.
// Latency 1 cycle from h/v to hit_o/addr_o; free-running, no backpressure.
module sprite_channel
   import sprite_pkg::*;
#(
   parameter int SIZE_H = SIZE_H_DEF,
   parameter int SIZE_V = SIZE_V_DEF,
   parameter int FRAMES = FRAMES_DEF,
   parameter int ADDR_W = 17
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 commit_i,
   input  spr_attr_t            live_i,
   input  logic [SPR_POS_W-1:0] h_cnt_i,
   input  logic [SPR_POS_W-1:0] v_cnt_i,
   output logic                 hit_o,
   output logic [ADDR_W-1:0]    addr_o
);

   localparam logic [SPR_POS_W:0] SPAN_H      = (SPR_POS_W+1)'(SIZE_H);
   localparam logic [SPR_POS_W:0] SPAN_V      = (SPR_POS_W+1)'(SIZE_V);
   localparam logic [ADDR_W-1:0]  ROW_WORDS   = ADDR_W'(SIZE_H);
   localparam logic [ADDR_W-1:0]  FRAME_WORDS = ADDR_W'(SIZE_H * SIZE_V);

   spr_attr_t               shadow_q, shadow_d;
   logic                    hit_q, hit_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [SPR_POS_W:0]      h_ext, v_ext, h_end, v_end;
   logic [SPR_POS_W-1:0]    dh, dv;
   logic [SPR_FRAME_W-1:0]  frame_c;

   always_comb begin
      shadow_d = commit_i ? live_i : shadow_q;

      // One extra bit keeps pos+size from wrapping, so sprites clip at the right/bottom edge.
      h_ext = {1'b0, h_cnt_i};
      v_ext = {1'b0, v_cnt_i};
      h_end = {1'b0, shadow_q.pos_h} + SPAN_H;
      v_end = {1'b0, shadow_q.pos_v} + SPAN_V;

      hit_d = shadow_q.en
              && (h_ext >= {1'b0, shadow_q.pos_h}) && (h_ext < h_end)
              && (v_ext >= {1'b0, shadow_q.pos_v}) && (v_ext < v_end);

      dh      = h_cnt_i - shadow_q.pos_h;
      dv      = v_cnt_i - shadow_q.pos_v;
      frame_c = clamp_frame(shadow_q.frame, FRAMES);

      addr_d = '0;
      if (hit_d) begin
         addr_d = ADDR_W'(frame_c) * FRAME_WORDS + ADDR_W'(dv) * ROW_WORDS + ADDR_W'(dh);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadow_q <= '0;
         hit_q    <= 1'b0;
         addr_q   <= '0;
      end else begin
         shadow_q <= shadow_d;
         hit_q    <= hit_d;
         addr_q   <= addr_d;
      end
   end

   assign hit_o  = hit_q;
   assign addr_o = addr_q;

endmodule

// File: rtl/sprite_compositor.sv
// N-channel sprite compositor: per-channel BRAM addressing, colour-key transparency, fixed-priority merge.
// Latency 2+BRAM_LAT cycles from h/v to rgb and syncs; streams at pixel rate, no backpressure.
module sprite_compositor
#(
   parameter int          N_SPR     = 4,
   parameter int          SIZE_H    = sprite_pkg::SIZE_H_DEF,
   parameter int          SIZE_V    = sprite_pkg::SIZE_V_DEF,
   parameter int          FRAMES    = sprite_pkg::FRAMES_DEF,
   parameter int          ADDR_W    = 17,
   parameter int          BRAM_LAT  = 1,
   parameter logic [11:0] KEY_COLOR = sprite_pkg::KEY_COLOR_DEF,
   parameter int          V_ACTIVE  = sprite_pkg::V_ACTIVE_DEF
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     valid_i,
   input  logic [9:0]               h_cnt_i,
   input  logic [9:0]               v_cnt_i,
   input  logic                     hsync_i,
   input  logic                     vsync_i,
   input  logic [N_SPR-1:0]         spr_en_i,
   input  logic [N_SPR*10-1:0]      spr_pos_h_i,
   input  logic [N_SPR*10-1:0]      spr_pos_v_i,
   input  logic [N_SPR*4-1:0]       spr_frame_i,
   output logic [N_SPR*ADDR_W-1:0]  pixel_addr_o,
   input  logic [N_SPR*12-1:0]      pixel_in_i,
   input  logic [11:0]              bg_pixel_i,
   output logic [11:0]              rgb_o,
   output logic                     hsync_o,
   output logic                     vsync_o
);
   import sprite_pkg::*;

   // Delay-line word: {vsync, hsync, valid, hit[N_SPR-1:0]}
   localparam int          PW      = N_SPR + 3;
   localparam logic [2:0]  FLG_RST = 3'b110;
   localparam logic [PW-1:0] DLY_RST = {FLG_RST, {N_SPR{1'b0}}};

   logic                commit;
   logic [N_SPR-1:0]    hit_a;
   logic [2:0]          flg_q;
   logic [PW-1:0]       dly_q [BRAM_LAT];
   logic [PW-1:0]       al;
   logic [N_SPR-1:0]    al_hit;
   logic                al_valid, al_hs, al_vs;
   logic [11:0]         rgb_q, rgb_d;
   logic                hs_q, vs_q;

   assign commit = (h_cnt_i == '0) && (v_cnt_i == SPR_POS_W'(V_ACTIVE));

   for (genvar g = 0; g < N_SPR; g++) begin : g_ch
      spr_attr_t live;

      assign live = {spr_en_i[g],
                     spr_pos_h_i[SPR_POS_W*g +: SPR_POS_W],
                     spr_pos_v_i[SPR_POS_W*g +: SPR_POS_W],
                     spr_frame_i[SPR_FRAME_W*g +: SPR_FRAME_W]};

      sprite_channel #(
         .SIZE_H (SIZE_H),
         .SIZE_V (SIZE_V),
         .FRAMES (FRAMES),
         .ADDR_W (ADDR_W)
      ) u_ch (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .commit_i (commit),
         .live_i   (live),
         .h_cnt_i  (h_cnt_i),
         .v_cnt_i  (v_cnt_i),
         .hit_o    (hit_a[g]),
         .addr_o   (pixel_addr_o[ADDR_W*g +: ADDR_W])
      );
   end

   assign al       = dly_q[BRAM_LAT-1];
   assign al_hit   = al[N_SPR-1:0];
   assign al_valid = al[N_SPR];
   assign al_hs    = al[N_SPR+1];
   assign al_vs    = al[N_SPR+2];

   // Walk from lowest to highest priority so channel 0 has the final say.
   always_comb begin
      rgb_d = bg_pixel_i;
      for (int i = N_SPR - 1; i >= 0; i--) begin
         if (al_hit[i] && (pixel_in_i[12*i +: 12] != KEY_COLOR)) begin
            rgb_d = pixel_in_i[12*i +: 12];
         end
      end
      if (!al_valid) begin
         rgb_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         flg_q <= FLG_RST;
         for (int k = 0; k < BRAM_LAT; k++) begin
            dly_q[k] <= DLY_RST;
         end
         rgb_q <= '0;
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
      end else begin
         flg_q    <= {vsync_i, hsync_i, valid_i};
         dly_q[0] <= {flg_q, hit_a};
         for (int k = 1; k < BRAM_LAT; k++) begin
            dly_q[k] <= dly_q[k-1];
         end
         rgb_q <= rgb_d;
         hs_q  <= al_hs;
         vs_q  <= al_vs;
      end
   end

   assign rgb_o   = rgb_q;
   assign hsync_o = hs_q;
   assign vsync_o = vs_q;

endmodule
